// File: rtl/pixel_history_store.sv
// pixel_history_store: per-pixel DATA_W history RAM for a FRAME_W x FRAME_H frame.
// One read port with a fixed RD_LAT valid/sideband pipeline, one write port, zero-fill clear.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset (starts a full clear)
//   i_clear_req, o_busy runtime clear request (RUN only); high while clearing
//   i_rd_en/addr/x/y    read request + sideband, sampled every edge
//   o_rd_valid/data     read result, RD_LAT edges after the request
//   o_rd_addr_out/x/y   sideband travelling with the read
//   i_wr_en/addr/data   write port; out-of-frame addresses are dropped
//
// Macro PIXEL_HISTORY_STORE_WR_FWD_EN: forward writes still in flight to reads.

module pixel_history_store #(
  parameter int DATA_W  = 4,
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int ADDR_W  = 19,
  parameter int COORD_W = 10,
  parameter int RD_LAT  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear_req,
  output logic               o_busy,
  input  logic               i_rd_en,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  input  logic [COORD_W-1:0] i_rd_x,
  input  logic [COORD_W-1:0] i_rd_y,
  output logic               o_rd_valid,
  output logic [DATA_W-1:0]  o_rd_data,
  output logic [ADDR_W-1:0]  o_rd_addr_out,
  output logic [COORD_W-1:0] o_rd_x_out,
  output logic [COORD_W-1:0] o_rd_y_out,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0]  i_wr_data
);

  localparam int DEPTH  = FRAME_W * FRAME_H;
  localparam int HALF   = (DEPTH + 1) / 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NP     = RD_LAT - 2;
  localparam bit ODD    = (DEPTH % 2) == 1;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-2:0] LAST_K  = (ADDR_W - 1)'(HALF - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic               v;
    logic [DATA_W-1:0]  d;
    logic [ADDR_W-1:0]  a;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } beat_t;

  // ---------------- FSM ----------------
  state_t            r_state;
  state_t            w_state_nx;
  logic [ADDR_W-2:0] r_clr_k;
  logic [ADDR_W-2:0] w_clr_k_nx;

  logic w_run;
  logic w_clr_go;
  logic w_flush;
  logic w_rd_acc;
  logic w_wr_acc;

  assign w_run    = (r_state == ST_RUN);
  assign w_clr_go = w_run & i_clear_req;
  assign w_flush  = reset | w_clr_go;
  assign o_busy   = ~w_run;

  // A request on the clear edge is dropped, same as anything issued while busy.
  assign w_rd_acc = w_run & i_rd_en & ~i_clear_req;
  assign w_wr_acc = w_run & i_wr_en & ~i_clear_req
                  & ({1'b0, i_wr_addr} < DEPTH_L);

  always_comb begin
    w_state_nx = r_state;
    w_clr_k_nx = r_clr_k;
    unique case (r_state)
      ST_CLEAR: begin
        if (r_clr_k == LAST_K) begin
          w_state_nx = ST_RUN;
          w_clr_k_nx = '0;
        end else begin
          w_clr_k_nx = r_clr_k + 1'b1;
        end
      end
      ST_RUN: begin
        if (i_clear_req) begin
          w_state_nx = ST_CLEAR;
          w_clr_k_nx = '0;
        end
      end
      default: begin
        w_state_nx = ST_CLEAR;
        w_clr_k_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_clr_k <= '0;
    end else begin
      r_state <= w_state_nx;
      r_clr_k <= w_clr_k_nx;
    end
  end

  // ---------------- write pipeline ----------------
  // Two stages so a write commits two edges after acceptance:
  // reads sampled on the write edge or the next one still see old data.
  logic              r_ws1_v;
  logic [ADDR_W-1:0] r_ws1_a;
  logic [DATA_W-1:0] r_ws1_d;
  logic              r_ws2_v;
  logic [ADDR_W-1:0] r_ws2_a;
  logic [DATA_W-1:0] r_ws2_d;

  always_ff @(posedge clk) begin
    r_ws1_a <= i_wr_addr;
    r_ws1_d <= i_wr_data;
    r_ws2_a <= r_ws1_a;
    r_ws2_d <= r_ws1_d;
    if (w_flush) begin
      r_ws1_v <= 1'b0;
      r_ws2_v <= 1'b0;
    end else begin
      r_ws1_v <= w_wr_acc;
      r_ws2_v <= r_ws1_v;
    end
  end

  // ---------------- RAM ----------------
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rq;
  logic [ADDR_W-1:0] w_clr_even;
  logic [ADDR_W-1:0] w_clr_odd;
  logic              w_b_we;
  logic [MEM_AW-1:0] w_b_idx;
  logic [DATA_W-1:0] w_b_d;

  assign w_clr_even = {r_clr_k, 1'b0};
  assign w_clr_odd  = {r_clr_k, 1'b1};

  // Port B: user writes in RUN, odd half of each pair in CLEAR.
  // With an odd frame size the last pair has no odd pixel.
  always_comb begin
    w_b_we  = r_ws2_v;
    w_b_idx = r_ws2_a[MEM_AW-1:0];
    w_b_d   = r_ws2_d;
    if (!w_run) begin
      w_b_we  = !(ODD && (r_clr_k == LAST_K));
      w_b_idx = w_clr_odd[MEM_AW-1:0];
      w_b_d   = '0;
    end
  end

  // ---------------- read front end ----------------
  logic               r_s1_v;
  logic [ADDR_W-1:0]  r_s1_a;
  logic [COORD_W-1:0] r_s1_x;
  logic [COORD_W-1:0] r_s1_y;
  logic               r_s1_oor;
  logic               r_s2_v;
  logic [ADDR_W-1:0]  r_s2_a;
  logic [COORD_W-1:0] r_s2_x;
  logic [COORD_W-1:0] r_s2_y;
  logic               r_s2_oor;
  logic [DATA_W-1:0]  w_s2_d;

  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[w_clr_even[MEM_AW-1:0]] <= '0;
    end
    if (w_b_we) begin
      r_mem[w_b_idx] <= w_b_d;
    end
    r_rq <= r_mem[r_s1_a[MEM_AW-1:0]];
  end

`ifdef PIXEL_HISTORY_STORE_WR_FWD_EN
  logic              r_s2_hit;
  logic [DATA_W-1:0] r_s2_fd;
  logic              w_m1;
  logic              w_m2;

  // ws1 holds the write from the read's own edge, ws2 the one before;
  // both are still uncommitted when the RAM is read, ws1 is younger.
  assign w_m1 = r_ws1_v & (r_ws1_a == r_s1_a);
  assign w_m2 = r_ws2_v & (r_ws2_a == r_s1_a);

  always_ff @(posedge clk) begin
    r_s2_hit <= w_m1 | w_m2;
    r_s2_fd  <= w_m1 ? r_ws1_d : r_ws2_d;
  end
`endif

  always_ff @(posedge clk) begin
    r_s1_a   <= i_rd_addr;
    r_s1_x   <= i_rd_x;
    r_s1_y   <= i_rd_y;
    r_s1_oor <= ~({1'b0, i_rd_addr} < DEPTH_L);
    r_s2_a   <= r_s1_a;
    r_s2_x   <= r_s1_x;
    r_s2_y   <= r_s1_y;
    r_s2_oor <= r_s1_oor;
    if (w_flush) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      r_s1_v <= w_rd_acc;
      r_s2_v <= r_s1_v;
    end
  end

  always_comb begin
    w_s2_d = r_rq;
`ifdef PIXEL_HISTORY_STORE_WR_FWD_EN
    if (r_s2_hit) begin
      w_s2_d = r_s2_fd;
    end
`endif
    if (r_s2_oor) begin
      w_s2_d = '0;
    end
  end

  // ---------------- delay stages + outputs ----------------
  beat_t r_pipe [NP];
  logic  w_out_v;

  always_ff @(posedge clk) begin
    r_pipe[0] <= '{v: r_s2_v, d: w_s2_d, a: r_s2_a,
                   x: r_s2_x, y: r_s2_y};
    for (int i = 1; i < NP; i++) begin
      r_pipe[i] <= r_pipe[i-1];
    end
    if (w_flush) begin
      for (int i = 0; i < NP; i++) begin
        r_pipe[i].v <= 1'b0;
      end
    end
  end

  // The beat landing on the clear edge is in flight too, so it is dropped.
  assign w_out_v = r_pipe[NP-1].v & ~w_clr_go;

  logic               r_rd_valid;
  logic [DATA_W-1:0]  r_rd_data;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic [COORD_W-1:0] r_rd_x;
  logic [COORD_W-1:0] r_rd_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_addr  <= '0;
      r_rd_x     <= '0;
      r_rd_y     <= '0;
    end else begin
      r_rd_valid <= w_out_v;
      if (w_out_v) begin
        r_rd_data <= r_pipe[NP-1].d;
        r_rd_addr <= r_pipe[NP-1].a;
        r_rd_x    <= r_pipe[NP-1].x;
        r_rd_y    <= r_pipe[NP-1].y;
      end
    end
  end

  assign o_rd_valid    = r_rd_valid;
  assign o_rd_data     = r_rd_data;
  assign o_rd_addr_out = r_rd_addr;
  assign o_rd_x_out    = r_rd_x;
  assign o_rd_y_out    = r_rd_y;

endmodule
